// File: rtl/md5_msg_sched_if.sv
// md5_msg_sched_if: loader write port and round-ordered replay port of the MD5 message scheduler
interface md5_msg_sched_if #(
   parameter int WIDTH = 32
);
   logic             wr_en;
   logic [3:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_commit;
   logic             wr_ready;
   logic             rd_en;
   logic [WIDTH-1:0] o_word;
   logic [5:0]       o_idx;
   logic             o_valid;
   logic             o_first;
   logic             o_last;
   logic             blk_done;

   modport master (
      output wr_en, wr_addr, wr_data, wr_commit, rd_en,
      input  wr_ready, o_word, o_idx, o_valid, o_first, o_last, blk_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_commit, rd_en,
      output wr_ready, o_word, o_idx, o_valid, o_first, o_last, blk_done
   );
endinterface

// File: rtl/md5_msg_sched.sv
// md5_msg_sched: double-buffered 16-word block store replaying 64 words in MD5 round order
module md5_msg_sched #(
   parameter int WIDTH    = 32,
   parameter bit SCHED_EN = 1'b1
) (
   input logic             CLK,
   input logic             rst_n,
   md5_msg_sched_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem [2][16];
   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [5:0]       idx_q, idx_d;
   logic             done_q, done_d;
   logic             wr_ok;
   logic             load;
   logic             rd_sel;
   logic [5:0]       step;
   logic [WIDTH-1:0] rd_word;

   // word index for step i; only the low 4 bits of i matter since everything wraps mod 16
   function automatic logic [3:0] g_idx(input logic [5:0] i);
      if (!SCHED_EN) return i[3:0];
      case (i[5:4])
         2'd0:    return i[3:0];
         2'd1:    return i[3:0] * 4'd5 + 4'd1;
         2'd2:    return i[3:0] * 4'd3 + 4'd5;
         default: return i[3:0] * 4'd7;
      endcase
   endfunction

   assign wr_ok        = !full_q[wr_bank_q];
   assign bus.wr_ready = wr_ok;
   assign bus.o_word   = word_q;
   assign bus.o_idx    = idx_q;
   assign bus.o_valid  = (state_q == RUN);
   assign bus.o_first  = (state_q == RUN) && (idx_q == 6'd0);
   assign bus.o_last   = (state_q == RUN) && (idx_q == 6'd63);
   assign bus.blk_done = done_q;

   // loader writes land in the bank being filled; a same-cycle commit still takes the word
   always_ff @(posedge CLK) begin
      if (bus.wr_en && wr_ok) mem[wr_bank_q][bus.wr_addr] <= bus.wr_data;
   end

   // bank bookkeeping and replay sequencing; release of the last step can chain straight into the other bank
   always_comb begin
      state_d   = state_q;
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      word_d    = word_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      load      = 1'b0;
      rd_sel    = rd_bank_q;
      step      = 6'd0;
      if (bus.wr_commit && wr_ok) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.rd_en) begin
               if (idx_q != 6'd63) begin
                  load = 1'b1;
                  step = idx_q + 6'd1;
               end else begin
                  full_d[rd_bank_q] = 1'b0;
                  done_d            = 1'b1;
                  rd_bank_d         = ~rd_bank_q;
                  rd_sel            = ~rd_bank_q;
                  if (full_q[~rd_bank_q]) load = 1'b1;
                  else state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      rd_word = mem[rd_sel][g_idx(step)];
      if (load) begin
         word_d = rd_word;
         idx_d  = step;
      end
   end

   // all control state clears asynchronously; RAM contents are left as they are
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         word_q    <= '0;
         idx_q     <= 6'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         word_q    <= word_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
      end
   end
endmodule

// File: doc/md5_msg_sched.md
Name: md5_msg_sched

Overview:
- Double-buffered 16-word message block store sitting directly upstream of the MD5 core's per-round delay/shift stages.
- A loader writes one block into the free bank while the other bank is replayed.
- The replay presents 64 words in MD5 round order, one per accepted downstream enable, so the core sees a continuous word stream with no bubble between blocks.

Parameters:
- WIDTH, 32, message word width in bits.
- SCHED_EN, 1, 1 = MD5 round permutation of word index; 0 = linear index (i mod 16) for all 64 steps (debug/bypass).

Ports:
- CLK  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write wr_data into current write bank at wr_addr.
- wr_addr  in  4  word index 0..15 within block.
- wr_data  in  WIDTH  message word.
- wr_commit  in  1  marks current write bank full; write pointer toggles to other bank.
- wr_ready  out  1  current write bank is empty (writes/commit accepted).
- rd_en  in  1  downstream advance enable (same enable that drives the core's shift stages).
- o_word  out  WIDTH  current message word, registered.
- o_idx  out  6  step number 0..63 of o_word.
- o_valid  out  1  o_word/o_idx valid.
- o_first  out  1  o_idx == 0 and o_valid.
- o_last  out  1  o_idx == 63 and o_valid.
- blk_done  out  1  one-cycle pulse: step 63 consumed, bank released.

Behaviour:
- Reset (rst_n low, async): both bank-full flags 0, wr bank = 0, rd bank = 0, o_valid 0, o_word 0, o_idx 0, blk_done 0; wr_ready = 1 after release. RAM contents not reset, don't-care.
- Storage: 2 banks x 16 x WIDTH distributed RAM, synchronous write, asynchronous read feeding the o_word register.
- Write side:
  - wr_en with wr_ready = 1 writes mem[wr_bank][wr_addr]; wr_en with wr_ready = 0 is ignored, no RAM change.
  - wr_commit with wr_ready = 1 sets full[wr_bank] and toggles wr_bank at that edge. wr_commit with wr_ready = 0 is ignored.
  - wr_en and wr_commit in the same cycle: the word is written into the bank being committed.
- Word index g(i) when SCHED_EN = 1:
  - i 0..15: i
  - i 16..31: (5i+1) mod 16
  - i 32..47: (3i+5) mod 16
  - i 48..63: 7i mod 16
  - All arithmetic is truncated to 4 bits.
- Read state machine:
  - IDLE (o_valid = 0): if full[rd_bank], load o_word <= mem[rd_bank][g(0)], o_idx <= 0, o_valid <= 1. This prefetch needs no rd_en; go to RUN.
  - RUN: o_word/o_idx hold while rd_en = 0. On rd_en with o_idx < 63: o_idx++, o_word <= mem[rd_bank][g(o_idx+1)].
  - RUN, rd_en with o_idx = 63: clear full[rd_bank], pulse blk_done, toggle rd_bank.
    - If the other bank is full, load its step-0 word in the same edge (o_valid stays 1, zero-bubble) and stay in RUN.
    - Otherwise o_valid <= 0 and go to IDLE.
- Latency: commit at edge E -> o_valid = 1 after edge E+1 (full flag visible combinationally to the IDLE load).
- Bank released at step-63 consume edge; wr_ready rises the same cycle if wr_bank points to it.
- Simultaneous commit and release on the same bank are impossible: write and read banks differ whenever that bank is full.
- rd_en while o_valid = 0: ignored.
- Reset mid-block: all state cleared asynchronously; the partial block is discarded.

Test Plan:
- Reset -> o_valid 0, o_word 0, wr_ready 1; write words mem[k] = 32'h1000_0000+k for k = 0..15, commit, rd_en held 1 -> o_valid after 2 edges. o_word sequence: 0x10000000..0x1000000F, then 0x10000001, 0x10000006, 0x1000000B (idx 16..18), 0x10000005 (idx 32), 0x10000000, 0x10000007 (idx 48, 49). blk_done pulses once after idx 63.
- Two blocks committed back-to-back (second tagged 0x2000_00xx), rd_en constant 1 -> idx 63 of block A is followed next cycle by idx 0 = 0x20000000, o_valid never drops; 128 consecutive valid words.
- rd_en toggled 1,0,0,1 pattern -> o_word/o_idx hold on every rd_en = 0 cycle, no skipped or repeated idx.
- Both banks full (commit twice, rd_en = 0) -> wr_ready 0; third wr_en to addr 3 with 0xDEADBEEF and third wr_commit ignored; replayed data unchanged.
- wr_en + wr_commit same cycle on addr 15 with 0xCAFEF00D -> step 15 output = 0xCAFEF00D.
- SCHED_EN = 0 -> idx 16..31 output word 0..15 in linear order.
- rst_n pulsed low at idx 20 -> o_valid 0 immediately (async); after release wr_ready 1, no stale output without a new commit.
